// File: rtl/gate_pkg.sv
// Shared types and helpers for the pipelined bitwise logic unit.
package gate_pkg;

    localparam int MAX_WIDTH  = 64;
    localparam int MAX_STAGES = 4;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NAND = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOT  = 3'd6,
        OP_PASS = 3'd7
    } op_t;

    // One bit of the selected function; every operation is purely bitwise.
    function automatic logic bit_eval(input logic a, input logic b, input op_t op);
        logic r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = ~(a ^ b);
            OP_NOT:  r = ~a;
            OP_PASS: r = a;
            default: r = a;
        endcase
        return r;
    endfunction

    // Full-width evaluation; callers narrower than MAX_WIDTH use the low bits.
    function automatic logic [MAX_WIDTH-1:0] logic_eval(input logic [MAX_WIDTH-1:0] a,
                                                        input logic [MAX_WIDTH-1:0] b,
                                                        input op_t op);
        logic [MAX_WIDTH-1:0] r;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            r[i] = bit_eval(a[i], b[i], op);
        end
        return r;
    endfunction

endpackage

// File: rtl/gate_pipe_stage.sv
// One pipeline slot: payload register, valid bit and the advance decision.
// The slot may load whenever it is empty or its current content leaves this cycle.
module gate_pipe_stage
    import gate_pkg::*;
#(
    parameter int PW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid_i,
    input  logic [PW-1:0] up_data_i,
    output logic          up_ready_o,
    output logic          dn_valid_o,
    output logic [PW-1:0] dn_data_o,
    input  logic          dn_ready_i
);

    logic          valid_q;
    logic          valid_d;
    logic [PW-1:0] data_q;
    logic [PW-1:0] data_d;
    logic          advance_s;

    assign advance_s  = !valid_q || dn_ready_i;
    assign up_ready_o = advance_s;
    assign dn_valid_o = valid_q;
    assign dn_data_o  = data_q;

    // Next-state: take upstream content when advancing, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (advance_s) begin
            valid_d = up_valid_i;
            if (up_valid_i) begin
                data_d = up_data_i;
            end else begin
                data_d = data_q;
            end
        end else begin
            valid_d = valid_q;
            data_d  = data_q;
        end
    end

    // Slot register with synchronous clear that drops any in-flight content.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/gate_array_pipe.sv
// Pipelined WIDTH-bit bitwise logic unit with valid/ready flow control.
// The function, zero flag and parity are computed at accept and ride along
// through STAGES slots; later slots only delay. Ready ripples back
// combinationally from out_ready so a full pipe can accept and emit together.
module gate_array_pipe
    import gate_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             parity
);

    localparam int PW = WIDTH + 2;

    if (STAGES < 1 || STAGES > MAX_STAGES || WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_cfg
        $fatal(1, "gate_array_pipe: WIDTH must be 1..64 and STAGES 1..4");
    end

    logic [WIDTH-1:0] res_s;
    logic [PW-1:0]    payload_s;

    // Bitwise function of the current operands; op is only captured on accept.
    always_comb begin
        res_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            res_s[i] = bit_eval(a[i], b[i], op_t'(op));
        end
    end

    assign payload_s = {res_s, ~(|res_s), ^res_s};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic          up_valid_s;
        logic [PW-1:0] up_data_s;
        logic          up_ready_s;
        logic          dn_valid_s;
        logic [PW-1:0] dn_data_s;
        logic          dn_ready_s;

        if (k == 0) begin : g_head
            assign up_valid_s = in_valid;
            assign up_data_s  = payload_s;
        end else begin : g_body
            assign up_valid_s = g_stage[k-1].dn_valid_s;
            assign up_data_s  = g_stage[k-1].dn_data_s;
        end

        if (k == STAGES - 1) begin : g_tail
            assign dn_ready_s = out_ready;
        end else begin : g_link
            assign dn_ready_s = g_stage[k+1].up_ready_s;
        end

        gate_pipe_stage #(
            .PW(PW)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .up_valid_i (up_valid_s),
            .up_data_i  (up_data_s),
            .up_ready_o (up_ready_s),
            .dn_valid_o (dn_valid_s),
            .dn_data_o  (dn_data_s),
            .dn_ready_i (dn_ready_s)
        );
    end

    assign in_ready  = g_stage[0].up_ready_s;
    assign out_valid = g_stage[STAGES-1].dn_valid_s;
    assign y         = g_stage[STAGES-1].dn_data_s[PW-1:2];
    assign zero      = g_stage[STAGES-1].dn_data_s[1];
    assign parity    = g_stage[STAGES-1].dn_data_s[0];

endmodule

// File: tb/tb_gate_array_pipe.sv
// Scoreboard bench for gate_array_pipe (WIDTH=8/STAGES=2 plus a WIDTH=1/STAGES=1 instance).
module tb_gate_array_pipe;
    import gate_pkg::*;

    localparam int W = 8;
    localparam int S = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready, zero, parity;
    logic [W-1:0] a, b, y;
    logic [2:0]   op;

    logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_zero, s_parity;
    logic [0:0] s_a, s_b, s_y;
    logic [2:0] s_op;

    gate_array_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .zero(zero), .parity(parity)
    );

    gate_array_pipe #(.WIDTH(1), .STAGES(1)) dut_small (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .op(s_op), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .y(s_y), .zero(s_zero), .parity(s_parity)
    );

    typedef struct {
        logic [W-1:0] y;
        logic         z;
        logic         p;
        int           acc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   check_lat = 1'b0;
    bit   stream_on = 1'b0;
    bit   prev_stall = 1'b0;
    logic [W+1:0] prev_out;

    logic [W-1:0] tt_y [0:7] = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
    logic [63:0]  ea, eb, er;
    logic [W-1:0] ra, rb;
    logic [2:0]   rop;
    int           idle;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: stall stability and in-order scoreboard comparison on each output transfer.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (out_valid && !out_ready) begin
                if (prev_stall) begin
                    checks++;
                    if ({y, zero, parity} !== prev_out) begin
                        errors++;
                        $display("FAIL stall_stable got %h held %h", {y, zero, parity}, prev_out);
                    end
                end
                prev_stall = 1'b1;
                prev_out   = {y, zero, parity};
            end else begin
                prev_stall = 1'b0;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out got y=%h z=%b p=%b exp none", y, zero, parity);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({y, zero, parity} !== {mon_e.y, mon_e.z, mon_e.p}) begin
                        errors++;
                        $display("FAIL out_data got y=%h z=%b p=%b exp y=%h z=%b p=%b",
                                 y, zero, parity, mon_e.y, mon_e.z, mon_e.p);
                    end
                    if (check_lat) begin
                        checks++;
                        if (cyc - mon_e.acc != S - 1) begin
                            errors++;
                            $display("FAIL latency got %0d exp %0d", cyc - mon_e.acc, S - 1);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    // Offer one vector, push its expected result when it is accepted.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic [2:0] top, input logic [W-1:0] ey);
        exp_t e;
        bit   done;
        done     = 1'b0;
        a        = ta;
        b        = tb;
        op       = top;
        in_valid = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                e.y   = ey;
                e.z   = (ey == 8'h00);
                e.p   = ^ey;
                e.acc = cyc + 1;
                exp_q.push_back(e);
                done  = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout got no accept exp accept within 200 cycles");
        end
        in_valid = 1'b0;
        a        = W'($urandom);
        op       = 3'($urandom_range(0, 7));
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = 8'h00; b = 8'h00; op = 3'd0;
        s_in_valid = 1'b0; s_out_ready = 1'b0; s_a = 1'b0; s_b = 1'b0; s_op = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_y", 64'(y), 64'd0);
        chk("reset_flags", 64'({zero, parity}), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Truth table, back-to-back with latency check.
        check_lat = 1'b1;
        for (int i = 0; i < 8; i++) send(8'hF0, 8'hCC, 3'(i), tt_y[i]);
        drain();
        check_lat = 1'b0;

        // Flags.
        send(8'h00, 8'h00, 3'd1, 8'h00);
        send(8'h07, 8'h00, 3'd1, 8'h07);
        drain();

        // Backpressure: two accepted, third waits until the consumer resumes.
        out_ready = 1'b0;
        send(8'hAA, 8'h55, 3'd4, 8'hFF);
        send(8'hAA, 8'h0F, 3'd0, 8'h0A);
        in_valid = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_full", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        fork
            send(8'h3C, 8'h3C, 3'd5, 8'hFF);
            begin
                repeat (4) begin @(posedge clk); #1; end
                out_ready = 1'b1;
            end
        join
        drain();

        // Random streaming with random consumer duty.
        stream_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    idle = $urandom_range(0, 2);
                    repeat (idle) begin @(posedge clk); #1; end
                    ra  = W'($urandom);
                    rb  = W'($urandom);
                    rop = 3'($urandom_range(0, 7));
                    ea = 64'd0; eb = 64'd0;
                    ea[W-1:0] = ra;
                    eb[W-1:0] = rb;
                    er = logic_eval(ea, eb, op_t'(rop));
                    send(ra, rb, rop, er[W-1:0]);
                end
                stream_on = 1'b0;
            end
            begin
                while (stream_on) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two entries in flight.
        out_ready = 1'b0;
        send(8'h12, 8'h34, 3'd1, 8'h36);
        send(8'h56, 8'h78, 3'd4, 8'h2E);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_y", 64'(y), 64'd0);
        chk("rst_mid_flags", 64'({zero, parity}), 64'd0);
        chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("rst_mid_flushed", 64'(out_valid), 64'd0);

        // WIDTH=1, STAGES=1 instance: NOR of zeros one cycle after accept.
        @(posedge clk);
        #1;
        s_a = 1'b0; s_b = 1'b0; s_op = 3'd3; s_in_valid = 1'b1;
        @(negedge clk);
        chk("small_in_ready", 64'(s_in_ready), 64'd1);
        chk("small_idle_out", 64'(s_out_valid), 64'd0);
        @(posedge clk);
        #1;
        s_in_valid = 1'b0; s_op = 3'd0; s_a = 1'b1;
        @(negedge clk);
        chk("small_out_valid", 64'(s_out_valid), 64'd1);
        chk("small_y", 64'(s_y), 64'd1);
        chk("small_flags", 64'({s_zero, s_parity}), 64'd1);
        s_out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("small_emptied", 64'(s_out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
